matrix_op_sequencer: RTL

- Runs one matrix operation over stored matrices: add, scalar multiply, transpose or matrix multiply.
- Looks up operand metadata, checks dimensions, then fetches operand elements from the matrix storage read port one at a time.
- Accumulates each result element and writes it back to the storage write port in row-major order.
- Sits between the top-level command FSM and the matrix storage block. It is the only block that reads operands or writes results.

---
 rtl/matrix_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_op_sequencer.sv
// Matrix operation sequencer: looks up operand metadata, checks dimensions, then
// streams operand reads and row-major result writes for add, scale, transpose and matmul.
module matrix_op_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ID_W      = 4,
    parameter int IDX_W     = 5,
    parameter int NUM_SLOTS = 10,
    parameter int ACC_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ID_W-1:0]   id_a,
    input  logic [ID_W-1:0]   id_b,
    input  logic [DATA_W-1:0] scalar,
    input  logic [ID_W-1:0]   dst_id,
    output logic [ID_W-1:0]   meta_id,
    input  logic [2:0]        meta_m,
    input  logic [2:0]        meta_n,
    input  logic              meta_valid,
    output logic              rd_en,
    output logic [ID_W-1:0]   rd_id,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ID_W-1:0]   wr_id,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        wr_m,
    output logic [2:0]        wr_n,
    output logic              wr_last,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    // state   | meaning
    // IDLE    | waiting for start
    // META_A  | look up operand A metadata
    // META_B  | look up operand B metadata
    // CHECK   | range / validity / dimension checks, set result dims
    // RD_A    | request A element
    // RD_B    | capture A, request B element
    // ACC     | capture last read, update accumulator (matmul loops over k)
    // WR      | write one result element
    // DONE    | completion pulse
    // ERR     | completion pulse with error
    typedef enum logic [3:0] {
        S_IDLE, S_META_A, S_META_B, S_CHECK, S_RD_A,
        S_RD_B, S_ACC, S_WR, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SCL = 2'd1;
    localparam logic [1:0] OP_TRN = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [ID_W-1:0]   id_a_q, id_b_q, dst_q;
    logic [DATA_W-1:0] scalar_q;
    logic [2:0]        ma_q, na_q, mb_q, nb_q;
    logic              va_q, vb_q;
    logic [2:0]        rm_q, rn_q;
    logic [2:0]        r_q, c_q, k_q;
    logic [DATA_W-1:0] a_q;
    logic [ACC_W-1:0]  acc_q;
    logic [1:0]        err_q;

    logic              uses_b;
    logic [1:0]        chk_code;
    logic [2:0]        rm_nxt, rn_nxt;
    logic [ACC_W-1:0]  acc_nxt;
    logic              k_more, col_end, last_elem;

    function automatic logic slot_bad(input logic [ID_W-1:0] id);
        return 32'(id) >= 32'(NUM_SLOTS);
    endfunction

    function automatic logic [IDX_W-1:0] lin_idx(input logic [2:0] row,
                                                 input logic [2:0] stride,
                                                 input logic [2:0] col);
        return IDX_W'(row) * IDX_W'(stride) + IDX_W'(col);
    endfunction

    assign uses_b    = (op_q == OP_ADD) || (op_q == OP_MUL);
    assign k_more    = (4'(k_q) + 4'd1) < 4'(na_q);
    assign col_end   = (c_q == rn_q - 3'd1);
    assign last_elem = col_end && (r_q == rm_q - 3'd1);

    // Range errors outrank validity, which outranks dimension mismatch.
    always_comb begin
        chk_code = 2'd0;
        if (slot_bad(id_a_q) || slot_bad(dst_q) || (uses_b && slot_bad(id_b_q)))
            chk_code = 2'd3;
        else if (!va_q || (uses_b && !vb_q))
            chk_code = 2'd1;
        else if ((op_q == OP_ADD) && ((ma_q != mb_q) || (na_q != nb_q)))
            chk_code = 2'd2;
        else if ((op_q == OP_MUL) && (na_q != mb_q))
            chk_code = 2'd2;
    end

    always_comb begin
        rm_nxt = ma_q;
        rn_nxt = na_q;
        case (op_q)
            OP_TRN: begin
                rm_nxt = na_q;
                rn_nxt = ma_q;
            end
            OP_MUL:  rn_nxt = nb_q;
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_ADD:  acc_nxt = ACC_W'(a_q) + ACC_W'(rd_data);
            OP_SCL:  acc_nxt = ACC_W'(rd_data) * ACC_W'(scalar_q);
            OP_TRN:  acc_nxt = ACC_W'(rd_data);
            default: acc_nxt = acc_q + ACC_W'(a_q) * ACC_W'(rd_data);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        meta_id   = '0;
        rd_en     = 1'b0;
        rd_id     = '0;
        rd_idx    = '0;
        wr_en     = 1'b0;
        wr_id     = '0;
        wr_idx    = '0;
        wr_data   = '0;
        wr_last   = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_META_A;
            S_META_A: begin
                meta_id   = id_a_q;
                state_nxt = S_META_B;
            end
            S_META_B: begin
                meta_id   = id_b_q;
                state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = (chk_code != 2'd0) ? S_ERR : S_RD_A;
            S_RD_A: begin
                rd_en = 1'b1;
                rd_id = id_a_q;
                case (op_q)
                    OP_TRN:  rd_idx = lin_idx(c_q, na_q, r_q);
                    OP_MUL:  rd_idx = lin_idx(r_q, na_q, k_q);
                    default: rd_idx = lin_idx(r_q, na_q, c_q);
                endcase
                state_nxt = uses_b ? S_RD_B : S_ACC;
            end
            S_RD_B: begin
                rd_en     = 1'b1;
                rd_id     = id_b_q;
                rd_idx    = (op_q == OP_MUL) ? lin_idx(k_q, nb_q, c_q) : lin_idx(r_q, nb_q, c_q);
                state_nxt = S_ACC;
            end
            S_ACC: state_nxt = ((op_q == OP_MUL) && k_more) ? S_RD_A : S_WR;
            S_WR: begin
                wr_en     = 1'b1;
                wr_id     = dst_q;
                wr_idx    = lin_idx(r_q, rn_q, c_q);
                wr_data   = acc_q[DATA_W-1:0];
                wr_last   = last_elem;
                state_nxt = last_elem ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                done      = 1'b1;
                error     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            id_a_q   <= '0;
            id_b_q   <= '0;
            dst_q    <= '0;
            scalar_q <= '0;
            ma_q     <= '0;
            na_q     <= '0;
            mb_q     <= '0;
            nb_q     <= '0;
            va_q     <= 1'b0;
            vb_q     <= 1'b0;
            rm_q     <= '0;
            rn_q     <= '0;
            r_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            err_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        id_a_q   <= id_a;
                        id_b_q   <= id_b;
                        scalar_q <= scalar;
                        dst_q    <= dst_id;
                        err_q    <= 2'd0;
                    end
                end
                S_META_A: begin
                    ma_q <= meta_m;
                    na_q <= meta_n;
                    va_q <= meta_valid;
                end
                S_META_B: begin
                    mb_q <= meta_m;
                    nb_q <= meta_n;
                    vb_q <= meta_valid;
                end
                S_CHECK: begin
                    if (chk_code != 2'd0) begin
                        err_q <= chk_code;
                    end else begin
                        rm_q  <= rm_nxt;
                        rn_q  <= rn_nxt;
                        r_q   <= '0;
                        c_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                S_RD_B: a_q <= rd_data;
                S_ACC: begin
                    acc_q <= acc_nxt;
                    if ((op_q == OP_MUL) && k_more) k_q <= k_q + 3'd1;
                end
                S_WR: begin
                    acc_q <= '0;
                    k_q   <= '0;
                    if (col_end) begin
                        c_q <= '0;
                        r_q <= r_q + 3'd1;
                    end else begin
                        c_q <= c_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign wr_m     = rm_q;
    assign wr_n     = rn_q;
    assign err_code = err_q;

endmodule
